// File: rtl/uart_tx_arb_if.sv
// Requester-side bundle for uart_tx_arb: one valid/ready/byte lane per core.
//   ReqValid : per-requester byte valid
//   ReqData  : per-requester byte, requester i in bits [8i+7:8i]
//   ReqReady : per-requester accept strobe from the arbiter
interface uart_tx_arb_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   ReqValid;
  logic [8*NUM_REQ-1:0] ReqData;
  logic [NUM_REQ-1:0]   ReqReady;

  modport master (output ReqValid, output ReqData, input ReqReady);
  modport slave  (input ReqValid, input ReqData, output ReqReady);
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter.
//   QClk     : clock
//   RstQnnnL : asynchronous active-low reset
//   req      : requester bundle (ReqValid / ReqData in, ReqReady out, combinational)
//   uart_tx  : serial line, LSB first, idle high
//   Busy     : frame in flight
//   GrantId  : requester owning the current or most recent frame
//   TxDone   : one-cycle pulse in the last stop-bit cycle
module uart_tx_arb #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned CLK_PER_BIT = 43
) (
  input  logic                       QClk,
  input  logic                       RstQnnnL,
  uart_tx_arb_if.slave               req,
  output logic                       uart_tx,
  output logic                       Busy,
  output logic [$clog2(NUM_REQ)-1:0] GrantId,
  output logic                       TxDone
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [ID_W-1:0]  ID_LAST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       bit_q, bit_n;
  logic [7:0]       shift_q, shift_n;
  logic [ID_W-1:0]  last_q, last_n;
  logic [ID_W-1:0]  gid_q, gid_n;
  logic             tx_q, tx_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  logic [ID_W-1:0]  grant_c;
  logic             any_valid_c;
  logic [7:0]       data_arr [NUM_REQ];
  logic             bit_end;

  // Unpack the flat data bus into per-requester bytes.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      data_arr[i] = req.ReqData[8*i +: 8];
    end
  end

  // Round-robin pick: scan downward so the closest index after last_q wins.
  always_comb begin
    int idx;
    grant_c     = '0;
    any_valid_c = 1'b0;
    idx         = 0;
    for (int i = int'(NUM_REQ); i > 0; i--) begin
      idx = (int'(last_q) + i) % int'(NUM_REQ);
      if (req.ReqValid[ID_W'(idx)]) begin
        grant_c     = ID_W'(idx);
        any_valid_c = 1'b1;
      end
    end
  end

  // Accept strobe; held low while reset is asserted.
  always_comb begin
    req.ReqReady = '0;
    if (RstQnnnL && (state_q == IDLE) && any_valid_c) begin
      req.ReqReady[grant_c] = 1'b1;
    end
  end

  assign bit_end = (cnt_q == CNT_MAX);

  // Next-state and datapath.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    last_n  = last_q;
    gid_n   = gid_q;
    tx_n    = tx_q;

    unique case (state_q)
      IDLE: begin
        tx_n  = 1'b1;
        cnt_n = '0;
        if (any_valid_c) begin
          shift_n = data_arr[grant_c];
          last_n  = grant_c;
          gid_n   = grant_c;
          bit_n   = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          tx_n    = shift_q[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_q == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_n   = bit_q + 3'd1;
            shift_n = {1'b0, shift_q[7:1]};
            tx_n    = shift_q[1];
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          tx_n    = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered status derived from the upcoming state.
  assign busy_n = (state_n != IDLE);
  assign done_n = (state_n == STOP) && (cnt_n == CNT_MAX);

  // State and datapath registers.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= ID_LAST;
      gid_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      last_q  <= last_n;
      gid_q   <= gid_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign uart_tx = tx_q;
  assign Busy    = busy_q;
  assign GrantId = gid_q;
  assign TxDone  = done_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (NUM_REQ=4, CLK_PER_BIT=4): expected frames are
// queued as requests are driven and popped as the serial line is decoded.
module tb_uart_tx_arb;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CPB     = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] gid;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_tx;
  logic       busy;
  logic [1:0] grant_id;
  logic       tx_done;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];

  uart_tx_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arb #(.NUM_REQ(NUM_REQ), .CLK_PER_BIT(CPB)) dut (
    .QClk     (clk),
    .RstQnnnL (rst_n),
    .req      (bus),
    .uart_tx  (uart_tx),
    .Busy     (busy),
    .GrantId  (grant_id),
    .TxDone   (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; decodes one 40-cycle frame and checks it against the queue head.
  task automatic check_frame(input string tag, output int start_cyc);
    exp_t        e;
    logic [39:0] samp;
    logic [39:0] dn;
    logic [9:0]  bits;
    logic [3:0]  grp;
    start_cyc = 0;
    for (int w = 0; w < 100 && uart_tx !== 1'b0; w++) @(negedge clk);
    if (uart_tx !== 1'b0) begin
      chk({tag, "_start_timeout"}, 64'(uart_tx), 64'd0);
      return;
    end
    start_cyc = cyc;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_frame"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_grant_id"}, 64'(grant_id), 64'(e.gid));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    for (int j = 0; j < 40; j++) begin
      samp[j] = uart_tx;
      dn[j]   = tx_done;
      if (j == 20) chk({tag, "_ready_while_busy"}, 64'(bus.ReqReady), 64'd0);
      if (j < 39) @(negedge clk);
    end
    bits = {1'b1, e.data, 1'b0};
    for (int k = 0; k < 10; k++) begin
      grp = samp[4*k +: 4];
      chk($sformatf("%s_bit%0d", tag, k), 64'(grp), 64'({4{bits[k]}}));
    end
    chk({tag, "_txdone"}, 64'(dn), 64'h80_0000_0000);
  endtask

  initial begin
    int   s;
    int   starts[5];
    logic bad_tx, bad_busy, bad_done;

    bus.ReqValid = '0;
    bus.ReqData  = '0;

    // Reset values with a requester already waiting.
    bus.ReqValid = 4'b0100;
    bus.ReqData[23:16] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(uart_tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(tx_done), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_ready", 64'(bus.ReqReady), 64'd0);

    // Single byte 0xA5 from requester 2.
    rst_n = 1'b1;
    sb.push_back('{data: 8'hA5, gid: 2'd2});
    #1 chk("single_ready", 64'(bus.ReqReady), 64'b0100);
    @(negedge clk);
    chk("single_ready_drop", 64'(bus.ReqReady), 64'd0);
    bus.ReqValid = '0;
    check_frame("single", s);
    @(negedge clk);
    chk("single_idle_busy", 64'(busy), 64'd0);
    chk("single_gid_hold", 64'(grant_id), 64'd2);

    // Serve 3, then both 1 and 3 valid with last grant 3: wraps to 1 first.
    bus.ReqValid = 4'b1000;
    bus.ReqData[31:24] = 8'h5A;
    bus.ReqData[15:8]  = 8'hC6;
    sb.push_back('{data: 8'h5A, gid: 2'd3});
    check_frame("pre_wrap", s);
    bus.ReqValid = 4'b1010;
    sb.push_back('{data: 8'hC6, gid: 2'd1});
    sb.push_back('{data: 8'h5A, gid: 2'd3});
    check_frame("wrap_first", s);
    check_frame("wrap_second", s);
    bus.ReqValid = '0;

    // Data changes right after the handshake must not reach the line.
    bus.ReqValid = 4'b0001;
    bus.ReqData[7:0] = 8'h3C;
    sb.push_back('{data: 8'h3C, gid: 2'd0});
    @(negedge clk);
    chk("stab_ready", 64'(bus.ReqReady), 64'b0001);
    @(negedge clk);
    bus.ReqData[7:0] = 8'hFF;
    bus.ReqValid = '0;
    check_frame("stab", s);

    // Idle line.
    bad_tx = 1'b0; bad_busy = 1'b0; bad_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad_tx = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
      if (tx_done !== 1'b0) bad_done = 1'b1;
    end
    chk("idle_tx", 64'(bad_tx), 64'd0);
    chk("idle_busy", 64'(bad_busy), 64'd0);
    chk("idle_done", 64'(bad_done), 64'd0);

    // Reset during data bit 3 of a 0x00 frame from requester 2.
    bus.ReqValid = 4'b0100;
    bus.ReqData[23:16] = 8'h00;
    #1 chk("abort_ready", 64'(bus.ReqReady), 64'b0100);
    @(negedge clk);
    chk("abort_start", 64'(uart_tx), 64'd0);
    bus.ReqValid = '0;
    repeat (17) @(negedge clk);
    chk("abort_bit3_tx", 64'(uart_tx), 64'd0);
    chk("abort_bit3_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    bus.ReqValid = 4'b0010;
    bus.ReqData[15:8] = 8'hC3;
    #1;
    chk("abort_rst_tx", 64'(uart_tx), 64'd1);
    chk("abort_rst_busy", 64'(busy), 64'd0);
    chk("abort_rst_gid", 64'(grant_id), 64'd0);
    chk("abort_rst_done", 64'(tx_done), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_rst_ready", 64'(bus.ReqReady), 64'd0);
    rst_n = 1'b1;
    sb.push_back('{data: 8'hC3, gid: 2'd1});
    #1 chk("abort_release_ready", 64'(bus.ReqReady), 64'b0010);
    check_frame("after_abort", s);
    bus.ReqValid = '0;

    // All requesters valid from reset: grant order 0,1,2,3,0, 41 cycles apart.
    @(negedge clk);
    rst_n = 1'b0;
    bus.ReqData = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.ReqValid = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{data: 8'h11, gid: 2'd0});
    sb.push_back('{data: 8'h22, gid: 2'd1});
    sb.push_back('{data: 8'h33, gid: 2'd2});
    sb.push_back('{data: 8'h44, gid: 2'd3});
    sb.push_back('{data: 8'h11, gid: 2'd0});
    for (int f = 0; f < 5; f++) begin
      check_frame($sformatf("rr%0d", f), starts[f]);
    end
    bus.ReqValid = '0;
    for (int f = 1; f < 5; f++) begin
      chk($sformatf("rr_spacing%0d", f), 64'(starts[f] - starts[f-1]), 64'd41);
    end

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
